// File: rtl/grf_wb_arbiter.sv
// Write-port arbiter for the 32x32 GRF: merges the in-order W stage (port 0) with a
// FIFO-buffered long-latency writeback (port 1) and exports a pending-write scoreboard.
module grf_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   p0_valid,
    input  logic [4:0]             p0_addr,
    input  logic [31:0]            p0_data,
    input  logic [31:0]            p0_pc,
    output logic                   p0_ready,
    input  logic                   p1_valid,
    input  logic [4:0]             p1_addr,
    input  logic [31:0]            p1_data,
    input  logic [31:0]            p1_pc,
    output logic                   p1_ready,
    output logic                   grf_we,
    output logic [4:0]             grf_a3,
    output logic [31:0]            grf_wd,
    output logic [31:0]            grf_pc,
    output logic [31:0]            pending,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [WW-1:0] LIMIT_C = WW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_P0,
        SRC_HEAD
    } src_e;

    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [WW-1:0] wait_cnt;
    logic          empty;
    logic          full;
    logic          force_head;
    logic          push;
    logic          pop;
    src_e          src;

    assign empty      = (count == '0);
    assign full       = (count == DEPTH_C);
    assign force_head = (wait_cnt >= LIMIT_C) && !empty;
    assign p0_ready   = !reset && !force_head;
    assign p1_ready   = !reset && !full;
    assign push       = p1_valid && p1_ready;
    assign pop        = (src == SRC_HEAD);
    assign fifo_count = count;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        src = SRC_NONE;
        if (force_head)    src = SRC_HEAD;
        else if (p0_valid) src = SRC_P0;
        else if (!empty)   src = SRC_HEAD;
    end

    // NOTE: storage is not reset; the pointers and count alone decide which slots are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= p1_addr;
            mem_data[wr_ptr] <= p1_data;
            mem_pc[wr_ptr]   <= p1_pc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Counts how long the current head has been passed over by port 0.
    always_ff @(posedge clk) begin
        if (reset || empty || pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LIMIT_C) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grf_we <= 1'b0;
            grf_a3 <= '0;
            grf_wd <= '0;
            grf_pc <= '0;
        end else begin
            case (src)
                SRC_HEAD: begin
                    grf_we <= 1'b1;
                    grf_a3 <= mem_addr[rd_ptr];
                    grf_wd <= mem_data[rd_ptr];
                    grf_pc <= mem_pc[rd_ptr];
                end
                SRC_P0: begin
                    grf_we <= 1'b1;
                    grf_a3 <= p0_addr;
                    grf_wd <= p0_data;
                    grf_pc <= p0_pc;
                end
                default: grf_we <= 1'b0;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below the entry count.
    logic [AW-1:0] slot_off;
    logic [AW-1:0] slot_idx;

    always_comb begin
        pending  = '0;
        slot_off = '0;
        slot_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_idx = AW'(i);
            slot_off = slot_idx - rd_ptr;
            if ({1'b0, slot_off} < count) pending[mem_addr[slot_idx]] = 1'b1;
        end
        if (grf_we) pending[grf_a3] = 1'b1;
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed + randomized bench for grf_wb_arbiter against a queue-based reference model.
module tb_grf_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        p0_valid;
    logic [4:0]  p0_addr;
    logic [31:0] p0_data;
    logic [31:0] p0_pc;
    logic        p0_ready;
    logic        p1_valid;
    logic [4:0]  p1_addr;
    logic [31:0] p1_data;
    logic [31:0] p1_pc;
    logic        p1_ready;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [31:0] pending;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    ent_t        mq[$];
    int          m_lost;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_pc;

    grf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_data(p0_data), .p0_pc(p0_pc), .p0_ready(p0_ready),
        .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_data(p1_data), .p1_pc(p1_pc), .p1_ready(p1_ready),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .pending(pending), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_lost = 0;
        m_we   = 1'b0;
        m_a3   = '0;
        m_wd   = '0;
        m_pc   = '0;
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (mq[i]) p[mq[i].addr] = 1'b1;
        if (m_we) p[m_a3] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // One clock: compare all outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        bit   frc;
        bit   take_head;
        bit   was_empty;
        ent_t e;
        @(negedge clk);
        frc = (m_lost >= LIMIT) && (mq.size() > 0);
        check("p0_ready", p0_ready, 32'(!reset && !frc));
        check("p1_ready", p1_ready, 32'(!reset && mq.size() < DEPTH));
        check("fifo_count", fifo_count, 32'(mq.size()));
        check("grf_we", grf_we, 32'(m_we));
        check("grf_a3", grf_a3, 32'(m_a3));
        check("grf_wd", grf_wd, m_wd);
        check("grf_pc", grf_pc, m_pc);
        check("pending", pending, model_pending());
        @(posedge clk);
        #1;
        if (reset) begin
            model_clear();
        end else begin
            was_empty = (mq.size() == 0);
            take_head = frc || (!p0_valid && !was_empty);
            if (take_head) begin
                e    = mq.pop_front();
                m_we = 1'b1;
                m_a3 = e.addr;
                m_wd = e.data;
                m_pc = e.pc;
            end else if (p0_valid) begin
                m_we = 1'b1;
                m_a3 = p0_addr;
                m_wd = p0_data;
                m_pc = p0_pc;
            end else begin
                m_we = 1'b0;
            end
            m_lost = (was_empty || take_head) ? 0 : ((m_lost + 1 > LIMIT) ? LIMIT : m_lost + 1);
            // Fullness is judged before this cycle's pop.
            if (p1_valid && (mq.size() + (take_head ? 1 : 0)) < DEPTH) begin
                e.addr = p1_addr;
                e.data = p1_data;
                e.pc   = p1_pc;
                mq.push_back(e);
            end
        end
    endtask

    task automatic drive_p0(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        p0_valid = v;
        p0_addr  = a;
        p0_data  = d;
        p0_pc    = pc;
    endtask

    task automatic drive_p1(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        p1_valid = v;
        p1_addr  = a;
        p1_data  = d;
        p1_pc    = pc;
    endtask

    initial begin
        logic [4:0] exp_addr;

        reset = 1'b1;
        drive_p0(1'b0, '0, '0, '0);
        drive_p1(1'b0, '0, '0, '0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_p0_ready", p0_ready, 0);
        check("rst_hold_p1_ready", p1_ready, 0);
        step();
        reset = 1'b0;
        step();

        // Port 0 alone: one-cycle latency.
        drive_p0(1'b1, 5'd5, 32'h1234_5678, 32'h0000_3000);
        step();
        p0_valid = 1'b0;
        check("p0_lat_we", grf_we, 1);
        check("p0_lat_a3", grf_a3, 5);
        check("p0_lat_wd", grf_wd, 32'h1234_5678);
        check("p0_lat_pc", grf_pc, 32'h0000_3000);
        step();
        check("p0_we_drop", grf_we, 0);

        // Port 1 alone: two-cycle latency, pending bit lifetime.
        drive_p1(1'b1, 5'd8, 32'hDEAD_BEEF, 32'h0000_4000);
        step();
        p1_valid = 1'b0;
        check("p1_pend_n1", pending[8], 1);
        step();
        check("p1_pend_n2", pending[8], 1);
        check("p1_lat_we", grf_we, 1);
        check("p1_lat_a3", grf_a3, 8);
        check("p1_lat_wd", grf_wd, 32'hDEAD_BEEF);
        step();
        check("p1_pend_n3", pending[8], 0);

        // Starvation: head loses LIMIT times, then is forced for exactly one cycle.
        drive_p0(1'b1, 5'd3, 32'h0000_0033, 32'h0000_5000);
        drive_p1(1'b1, 5'd9, 32'h0000_0099, 32'h0000_5004);
        step();
        p1_valid = 1'b0;
        for (int k = 0; k < LIMIT; k++) begin
            check("starve_lose_ready", p0_ready, 1);
            step();
        end
        check("starve_force_ready", p0_ready, 0);
        step();
        check("starve_release_ready", p0_ready, 1);
        check("starve_head_a3", grf_a3, 9);
        check("starve_head_we", grf_we, 1);
        step();
        p0_valid = 1'b0;
        step();

        // Fill to DEPTH behind a busy port 0, then a refused push during the forced pop.
        drive_p0(1'b1, 5'd4, 32'h0000_0044, 32'h0000_6000);
        for (int k = 0; k < DEPTH; k++) begin
            drive_p1(1'b1, 5'(10 + k), 32'hA000_0000 + 32'(k), 32'h0000_7000 + 32'(4 * k));
            step();
        end
        check("full_count", fifo_count, 4);
        check("full_p1_ready", p1_ready, 0);
        check("full_forced", p0_ready, 0);
        drive_p1(1'b1, 5'd14, 32'hBAD0_0000, 32'h0000_7FFF);
        step();
        drive_p0(1'b0, '0, '0, '0);
        p1_valid = 1'b0;
        check("full_refused_count", fifo_count, 3);
        check("drain_a3_0", grf_a3, 10);
        for (int k = 1; k < DEPTH; k++) begin
            step();
            exp_addr = 5'(10 + k);
            check("drain_order_a3", grf_a3, 32'(exp_addr));
            check("drain_order_wd", grf_wd, 32'hA000_0000 + 32'(k));
        end
        step();

        // Writes to $0 pass through without raising pending.
        drive_p1(1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_8000);
        step();
        p1_valid = 1'b0;
        check("r0_pend_n1", pending, 0);
        step();
        check("r0_we", grf_we, 1);
        check("r0_a3", grf_a3, 0);
        check("r0_wd", grf_wd, 32'hFFFF_FFFF);
        check("r0_pend_n2", pending, 0);
        step();

        // Reset with three buffered entries and a staged write.
        drive_p0(1'b1, 5'd6, 32'h0000_0066, 32'h0000_9000);
        for (int k = 0; k < 3; k++) begin
            drive_p1(1'b1, 5'(20 + k), 32'hC000_0000 + 32'(k), 32'h0000_9100);
            step();
        end
        drive_p0(1'b0, '0, '0, '0);
        p1_valid = 1'b0;
        check("pre_rst_count", fifo_count, 3);
        check("pre_rst_we", grf_we, 1);
        reset = 1'b1;
        #1;
        check("rst_p0_ready", p0_ready, 0);
        check("rst_p1_ready", p1_ready, 0);
        step();
        reset = 1'b0;
        check("post_rst_count", fifo_count, 0);
        check("post_rst_we", grf_we, 0);
        check("post_rst_pending", pending, 0);
        check("post_rst_wd", grf_wd, 0);

        // Randomized traffic with narrow addresses so pending bits overlap.
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive_p0(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, $urandom);
            drive_p1(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom, $urandom);
            step();
        end
        reset = 1'b0;
        drive_p0(1'b0, '0, '0, '0);
        drive_p1(1'b0, '0, '0, '0);
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Write-port arbiter for the 32×32 general register file. It shares the GRF's single write port (RegWrite/A3/WriteData/PC) between two writeback sources: port 0, the in-order pipeline W stage, and port 1, a long-latency unit (multiply/divide or late load return) whose results are buffered in a FIFO. It also exports a per-register pending scoreboard so the hazard unit can stall reads of registers whose buffered write has not yet reached the GRF.

## Interface
- DEPTH, 4, port-1 FIFO entries; a power of 2 and at least 2.
- STARVE_LIMIT, 3, consecutive cycles the FIFO head may lose arbitration before it is forced through; at least 1.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- p0_valid  in  1  pipeline write request.
- p0_addr  in  5  destination register.
- p0_data  in  32  write data.
- p0_pc  in  32  PC of the writing instruction.
- p0_ready  out  1  port-0 request is granted this cycle.
- p1_valid  in  1  long-latency write request.
- p1_addr  in  5  destination register.
- p1_data  in  32  write data.
- p1_pc  in  32  PC of the writing instruction.
- p1_ready  out  1  FIFO can accept an entry this cycle.
- grf_we  out  1  drives GRF RegWrite.
- grf_a3  out  5  drives GRF A3.
- grf_wd  out  32  drives GRF WriteData.
- grf_pc  out  32  drives GRF PC.
- pending  out  32  bit r=1 while a write to register r is buffered or staged.
- fifo_count  out  log2(DEPTH)+1  number of FIFO entries.

## Operation
- Port-1 push: a handshake occurs when p1_valid && p1_ready. p1_ready = !reset && (fifo_count != DEPTH). A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- FIFO is strictly in order. A pushed entry becomes the head no earlier than the next cycle; there is no bypass.
- wait_cnt (internal): increments each cycle in which the FIFO is non-empty and the head is not granted, saturating at STARVE_LIMIT. It clears on a head grant or when the FIFO is empty.
- force = (wait_cnt >= STARVE_LIMIT) && FIFO non-empty.
- Grant priority, evaluated each cycle:
  - if force, grant the FIFO head;
  - else if p0_valid, grant port 0;
  - else if the FIFO is non-empty, grant the head;
  - else no grant.
- p0_ready = !reset && !force. A port-0 request that is not ready must be held by the pipeline (stall).
- Granted {addr, data, pc} is registered into the output stage with grf_we=1. With no grant, grf_we=0 and the other outputs hold their previous values.
- Writes to $0 are forwarded unchanged; the GRF handles them. pending[0] is always 0.
- pending[r] = OR over valid FIFO entries and the output stage (when grf_we=1) of addr==r, for r≠0. It is combinational from registered state.
- Ordering between port 0 and port 1 for the same register is not guaranteed. Consumers must stall on pending.
- Simultaneous push and pop leaves fifo_count unchanged.
- Read/write pointers wrap modulo DEPTH.

## Timing
- Reset, at the clock edge with reset=1:
  - FIFO emptied, fifo_count=0, wait_cnt=0;
  - grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0, pending=0.
  - p0_ready=p1_ready=0 while reset is high. Inputs are ignored, and any in-flight FIFO contents are discarded.
- Port-0 latency: granted in cycle N, grf_we=1 in cycle N+1, GRF written at the end of N+1.
- Port-1 latency, no contention: pushed in cycle N, head and granted in N+1, grf_we=1 in N+2.
- Under continuous p0_valid with a non-empty FIFO, the head is granted in the cycle after it has lost STARVE_LIMIT times. port0 then sees p0_ready=0 for exactly that one cycle.
- A pending bit clears in the cycle after the corresponding grf_we=1 cycle, unless another staged or buffered write targets the same register.

## Test plan
- Reset mid-operation: 3 FIFO entries plus a staged write, then reset → next cycle fifo_count=0, grf_we=0, pending=0, grf_wd=0; p0_ready=p1_ready=0 during reset.
- Port 0 only: p0 {addr=5, data=0x12345678, pc=0x3000} in cycle N → cycle N+1 grf_we=1, grf_a3=5, grf_wd=0x12345678, grf_pc=0x3000; cycle N+2 grf_we=0.
- Port 1 only: push {addr=8, data=0xDEADBEEF} in cycle N → pending[8]=1 from N+1 through N+2; grf_we=1 with grf_a3=8 in N+2; pending[8]=0 in N+3.
- Starvation, STARVE_LIMIT=3: FIFO holds one entry and p0_valid is held high continuously → head loses 3 cycles; 4th cycle p0_ready=0 and head granted; the following cycle p0_ready=1.
- Full FIFO, DEPTH=4: p1_valid high with no grants → fifo_count reaches 4 and p1_ready=0. A simultaneous pop and p1_valid when full → no push, fifo_count becomes 3. Drain order equals push order, including across pointer wrap.
- $0 handling: p1 push addr=0, data=0xFFFFFFFF → pending stays 0; grf_we=1 with grf_a3=0 two cycles later.
